// File: rtl/spi_pkg.sv
// Shared types and mode constants for the SPI host serialiser.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_LEAD,
    SPI_XFER,
    SPI_TRAIL
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high in the last cycle of every CLK_DIV-cycle window.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic          FAST = (CLK_DIV == 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign tick      = r_tick;

  // r_tick is precomputed so it equals (r_cnt == LAST) without a combinational output
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt  <= '0;
      r_tick <= FAST;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt  <= '0;
      r_tick <= FAST;
    end else begin
      r_cnt  <= w_cnt_inc;
      r_tick <= (w_cnt_inc == LAST);
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Full-duplex SPI host serialiser with per-transfer CPOL/CPHA, one-hot active-low
// selects and a shared SCLK half-period divider.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CS     = 1,
  parameter int unsigned CLK_DIV    = 2,
  localparam int unsigned CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [1:0]            mode,
  input  logic [CS_W-1:0]       cs_idx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk_out,
  output logic [NUM_CS-1:0]     sel_out,
  output logic                  mosi_out,
  input  logic                  miso_in
);

  localparam int unsigned EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

  spi_state_t            r_state, w_state_nxt;
  spi_mode_t             r_mode, w_mode_nxt;
  logic [NUM_CS-1:0]     r_sel, w_sel_nxt, w_sel_dec;
  logic [DATA_WIDTH-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [DATA_WIDTH-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic [EW-1:0]         r_edge, w_edge_nxt, w_edge_inc;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_mosi, w_mosi_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_busy, r_ready;
  logic                  w_accept, w_tick;

  assign w_accept   = tx_valid & r_ready;
  assign w_edge_inc = r_edge + EW'(1);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .nrst  (nrst),
    .clear (w_accept),
    .tick  (w_tick)
  );

  // Out-of-range indices leave every select high; a single select is always used
  always_comb begin
    w_sel_dec = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      w_sel_dec[i] = (NUM_CS > 1) ? (cs_idx != CS_W'(i)) : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= SPI_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_sel_nxt      = r_sel;
    w_tx_sh_nxt    = r_tx_sh;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_data_nxt  = r_rx_data;
    w_edge_nxt     = r_edge;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_rx_valid_nxt = 1'b0;
    case (r_state)
      SPI_IDLE: begin
        w_mosi_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt = SPI_LEAD;
          w_mode_nxt  = spi_mode_t'(mode);
          w_sel_nxt   = w_sel_dec;
          w_sclk_nxt  = mode[1];
          w_edge_nxt  = '0;
          w_rx_sh_nxt = '0;
          // CPHA=0 presents the MSB before the first edge, so pre-shift it out here
          if (mode[0]) begin
            w_tx_sh_nxt = tx_data;
          end else begin
            w_tx_sh_nxt = {tx_data[DATA_WIDTH-2:0], 1'b0};
            w_mosi_nxt  = tx_data[DATA_WIDTH-1];
          end
        end
      end
      SPI_LEAD: begin
        w_sclk_nxt = r_mode.cpol;
        if (w_tick) w_state_nxt = SPI_XFER;
      end
      SPI_XFER: begin
        if (w_tick) begin
          w_sclk_nxt = ~r_sclk;
          w_edge_nxt = w_edge_inc;
          // odd edges lead; CPHA=0 samples on leading, CPHA=1 on trailing
          if (w_edge_inc[0] ^ r_mode.cpha) begin
            w_rx_sh_nxt = {r_rx_sh[DATA_WIDTH-2:0], miso_in};
          end else if (w_edge_inc != LAST_EDGE) begin
            w_mosi_nxt  = r_tx_sh[DATA_WIDTH-1];
            w_tx_sh_nxt = {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
          end
          if (w_edge_inc == LAST_EDGE) w_state_nxt = SPI_TRAIL;
        end
      end
      SPI_TRAIL: begin
        w_sclk_nxt = r_mode.cpol;
        if (w_tick) begin
          w_state_nxt    = SPI_IDLE;
          w_sel_nxt      = '1;
          w_mosi_nxt     = 1'b1;
          w_rx_data_nxt  = r_rx_sh;
          w_rx_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = SPI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mode     <= '0;
      r_sel      <= '1;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_edge     <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b1;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_sel      <= w_sel_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_edge     <= w_edge_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_busy     <= (w_state_nxt != SPI_IDLE);
      r_ready    <= (w_state_nxt == SPI_IDLE);
    end
  end

  assign tx_ready = r_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign sclk_out = r_sclk;
  assign sel_out  = r_sel;
  assign mosi_out = r_mosi;

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen: vector table, scoreboard and corner-case sequences.
module tb_spi_master_gen;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  always #5 clk = ~clk;

  // main instance: DATA_WIDTH=8, NUM_CS=2, CLK_DIV=2
  logic       tx_valid, tx_ready, rx_valid, busy, sclk_out, mosi_out, miso_in;
  logic [7:0] tx_data, rx_data;
  logic [1:0] mode, sel_out;
  logic [0:0] cs_idx;
  int         miso_sel;
  assign miso_in = (miso_sel == 0) ? mosi_out : (miso_sel == 1);

  spi_master_gen #(.DATA_WIDTH(8), .NUM_CS(2), .CLK_DIV(2)) u_dut (
    .clk(clk), .nrst(nrst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .mode(mode), .cs_idx(cs_idx), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk_out(sclk_out), .sel_out(sel_out), .mosi_out(mosi_out), .miso_in(miso_in)
  );

  // out-of-range select instance: NUM_CS=3 so cs_idx=3 is representable
  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_busy, b_sclk, b_mosi;
  logic [7:0] b_tx_data, b_rx_data;
  logic [1:0] b_mode, b_cs;
  logic [2:0] b_sel;

  spi_master_gen #(.DATA_WIDTH(8), .NUM_CS(3), .CLK_DIV(2)) u_dut_b (
    .clk(clk), .nrst(nrst), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
    .mode(b_mode), .cs_idx(b_cs), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy),
    .sclk_out(b_sclk), .sel_out(b_sel), .mosi_out(b_mosi), .miso_in(b_mosi)
  );

  // wide, undivided instance with a single select
  logic        c_tx_valid, c_tx_ready, c_rx_valid, c_busy, c_sclk, c_mosi;
  logic [15:0] c_tx_data, c_rx_data;
  logic [1:0]  c_mode;
  logic [0:0]  c_cs, c_sel;

  spi_master_gen #(.DATA_WIDTH(16), .NUM_CS(1), .CLK_DIV(1)) u_dut_c (
    .clk(clk), .nrst(nrst), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready), .tx_data(c_tx_data),
    .mode(c_mode), .cs_idx(c_cs), .rx_data(c_rx_data), .rx_valid(c_rx_valid), .busy(c_busy),
    .sclk_out(c_sclk), .sel_out(c_sel), .mosi_out(c_mosi), .miso_in(c_mosi)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         edges    = 0;
  int         sel_low  = 0;
  logic [7:0] cap      = '0;
  logic       prev_sclk = 1'b0;
  logic [1:0] cur_mode = 2'b00;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [1:0] mode;
    logic       cs;
    logic [7:0] tx;
    int         miso;    // 0 loopback, 1 tied high, 2 tied low
    logic [7:0] exp_rx;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock of the main instance: scoreboard on rx_valid, select and SCLK edge tracking
  task automatic step();
    logic [7:0] exp;
    @(negedge clk);
    cyc++;
    if (rx_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp});
      end
    end
    if (sel_out != 2'b11) sel_low++;
    if (sclk_out != prev_sclk) begin
      edges++;
      if (sclk_out == ~(cur_mode[1] ^ cur_mode[0])) cap = {cap[6:0], mosi_out};
    end
    prev_sclk = sclk_out;
  endtask

  task automatic run_xfer(input logic [1:0] m, input logic c, input logic [7:0] t, input int ms,
                          input logic [7:0] exp_rx, input logic [1:0] exp_sel);
    int n;
    miso_sel = ms; mode = m; cs_idx = c; tx_data = t; tx_valid = 1'b1; cur_mode = m;
    chk("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    sb_q.push_back(exp_rx);
    sel_low = 0;
    step();
    tx_valid = 1'b0; mode = ~m; cs_idx = ~c; tx_data = ~t;
    edges = 0; cap = '0;
    chk("lead_sel", {30'd0, sel_out}, {30'd0, exp_sel});
    chk("lead_busy", {31'd0, busy}, 32'd1);
    chk("lead_ready", {31'd0, tx_ready}, 32'd0);
    chk("lead_sclk", {31'd0, sclk_out}, {31'd0, m[1]});
    chk("lead_mosi", {31'd0, mosi_out}, {31'd0, (m[0] ? 1'b1 : t[7])});
    n = 1;
    while (rx_valid !== 1'b1 && n < 200) begin step(); n++; end
    chk("xfer_cycles", n, 37);
    chk("sel_low_cycles", sel_low, (exp_sel == 2'b11) ? 0 : 36);
    chk("sclk_edges", edges, 16);
    chk("mosi_word", {24'd0, cap}, {24'd0, t});
    chk("end_sel", {30'd0, sel_out}, 32'd3);
    chk("end_sclk_idle", {31'd0, sclk_out}, {31'd0, m[1]});
    chk("end_mosi", {31'd0, mosi_out}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_ready", {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t1, bad_sel, bad_rdy;
    vecs[0] = '{2'b00, 1'b1, 8'hA5, 0, 8'hA5, 2'b01};
    vecs[1] = '{2'b11, 1'b0, 8'h3C, 1, 8'hFF, 2'b10};
    vecs[2] = '{2'b01, 1'b0, 8'h96, 0, 8'h96, 2'b10};
    vecs[3] = '{2'b10, 1'b1, 8'h0F, 2, 8'h00, 2'b01};
    vecs[4] = '{2'b00, 1'b0, 8'hFF, 2, 8'h00, 2'b10};

    tx_valid = 0; tx_data = '0; mode = '0; cs_idx = '0; miso_sel = 0;
    b_tx_valid = 0; b_tx_data = '0; b_mode = '0; b_cs = '0;
    c_tx_valid = 0; c_tx_data = '0; c_mode = '0; c_cs = '0;
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_sel", {30'd0, sel_out}, 32'd3);
    chk("rst_sclk", {31'd0, sclk_out}, 32'd0);
    chk("rst_mosi", {31'd0, mosi_out}, 32'd1);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    nrst = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, tx_ready}, 32'd1);

    for (int i = 0; i < 5; i++)
      run_xfer(vecs[i].mode, vecs[i].cs, vecs[i].tx, vecs[i].miso, vecs[i].exp_rx, vecs[i].exp_sel);

    // back-to-back with tx_valid held: second accept lands in the rx_valid cycle
    miso_sel = 0; cur_mode = 2'b00; mode = 2'b00; cs_idx = 1'b0; tx_data = 8'h01; tx_valid = 1'b1;
    sb_q.push_back(8'h01);
    sb_q.push_back(8'h80);
    step();
    tx_data = 8'h80;
    n = 1;
    while (rx_valid !== 1'b1 && n < 200) begin step(); n++; end
    chk("b2b_first_len", n, 37);
    t1 = cyc;
    chk("b2b_ready_in_rxv", {31'd0, tx_ready}, 32'd1);
    chk("b2b_gap_sel", {30'd0, sel_out}, 32'd3);
    step();
    chk("b2b_second_sel", {30'd0, sel_out}, 32'd2);
    tx_valid = 1'b0;
    n = 1;
    while (rx_valid !== 1'b1 && n < 200) begin step(); n++; end
    chk("b2b_rx_spacing", cyc - t1, 37);

    // reset in the 10th XFER cycle of a mode-3 transfer (sclk high, mosi low there)
    cur_mode = 2'b11; mode = 2'b11; cs_idx = 1'b1; tx_data = 8'h00; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (11) step();
    chk("pre_rst_sclk", {31'd0, sclk_out}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("midrst_sel", {30'd0, sel_out}, 32'd3);
    chk("midrst_sclk", {31'd0, sclk_out}, 32'd0);
    chk("midrst_mosi", {31'd0, mosi_out}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, tx_ready}, 32'd0);
    step(); step();
    nrst = 1'b1;
    step();
    chk("midrst_ready_release", {31'd0, tx_ready}, 32'd1);
    repeat (40) step();
    run_xfer(2'b00, 1'b1, 8'h5A, 0, 8'h5A, 2'b01);

    // out-of-range select on the three-select instance
    b_tx_data = 8'hC3; b_mode = 2'b00; b_cs = 2'd3; b_tx_valid = 1'b1;
    chk("oor_ready_before", {31'd0, b_tx_ready}, 32'd1);
    n = 0; bad_sel = 0; bad_rdy = 0;
    do begin
      @(negedge clk);
      b_tx_valid = 1'b0;
      n++;
      if (b_sel !== 3'b111) bad_sel++;
      if (b_rx_valid !== 1'b1 && b_tx_ready !== 1'b0) bad_rdy++;
    end while (b_rx_valid !== 1'b1 && n < 200);
    chk("oor_len", n, 37);
    chk("oor_sel_high", bad_sel, 0);
    chk("oor_ready_low", bad_rdy, 0);
    chk("oor_rx_data", {24'd0, b_rx_data}, 32'hC3);

    // 16-bit, CLK_DIV=1, mode 1 loopback on the single-select instance
    c_tx_data = 16'hBEEF; c_mode = 2'b01; c_cs = 1'b1; c_tx_valid = 1'b1;
    n = 0; bad_sel = 0;
    do begin
      @(negedge clk);
      c_tx_valid = 1'b0;
      n++;
      if (c_sel === 1'b0) bad_sel++;
    end while (c_rx_valid !== 1'b1 && n < 200);
    chk("w16_len", n, 35);
    chk("w16_sel_low", bad_sel, 34);
    chk("w16_rx_data", {16'd0, c_rx_data}, 32'hBEEF);
    chk("w16_sclk_idle", {31'd0, c_sclk}, 32'd0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
